rx_byte_fifo: RTL

Receive-side byte buffer for the UART path. Sits directly downstream of the RX control FSM: captures each received byte on its `rx_done_sig` pulse, buffers up to 2^DEPTH_LOG2 bytes, and presents them to the consumer (loopback TX, command parser, host logic) through a first-word-fall-through valid/ready interface. Flags overflow when bytes arrive faster than they are drained.

---
 rtl/rx_byte_fifo_pkg.sv | 6 +
 rtl/rx_byte_fifo.sv | 71 +++++++
 2 files changed

// File: rtl/rx_byte_fifo_pkg.sv
// Shared UART constants: byte width and default RX FIFO depth, used by the
// RX/TX control blocks and the receive byte FIFO.
package rx_byte_fifo_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int RX_FIFO_DEPTH_LOG2 = 4;
endpackage

// File: rtl/rx_byte_fifo.sv
// Receive-side FWFT byte FIFO: captures RX bytes on rx_done_sig and presents
// them through valid/ready. A sticky flag records any byte dropped while full.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_done_sig,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  overflow_sig,
  input  logic                  clr_overflow
);
  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH_LOG2-1:0]        wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]          count;
  logic                         pop, wr_en, reject;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign pop    = rd_valid && rd_ready;
  assign wr_en  = rx_done_sig && (!fifo_full || pop);
  assign reject = rx_done_sig && fifo_full && !pop;

  assign rd_data    = mem[rd_ptr];
  assign rd_valid   = (count != '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mem <= '0;
    else if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else begin
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow_sig <= 1'b0;
    else if (reject)       overflow_sig <= 1'b1;
    else if (clr_overflow) overflow_sig <= 1'b0;
  end
endmodule
